lsu_rv32i: RTL and testbench

LSU_RV32I -- requirements
Module: lsu_rv32i

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/lsu_align_rv32i.sv | 29 ++
 rtl/lsu_rv32i.sv | 95 +++++++++
 tb/tb_lsu_rv32i.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: decoder encodings, LSU state enum and the access-legality check.
package rv32i_pkg;
  localparam logic [1:0] RD_LOAD = 2'b01;
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;
  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;
  // High for reserved encodings and for halfword/word accesses off their natural boundary.
  function automatic logic lsu_bad(input logic ld, input logic [2:0] lt, input logic [1:0] st,
                                   input logic [1:0] a);
    return ld ? (lt == 3'b011 || lt[2:1] == 2'b11 || ((lt == LT_LH || lt == LT_LHU) && a[0]) ||
                 (lt == LT_LW && a != 2'b00))
              : (st == 2'b11 || (st == ST_SH && a[0]) || (st == ST_SW && a != 2'b00));
  endfunction
endpackage

// File: rtl/lsu_align_rv32i.sv
// lsu_align_rv32i: load lane select/extend and store byte-enable/lane replication.
module lsu_align_rv32i import rv32i_pkg::*; (
  input  logic [1:0]  off_i,
  input  logic [2:0]  loadtype_i,
  input  logic [1:0]  storetype_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = 8'(rdata_i >> {off_i, 3'b000});
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    ld_data_o = loadtype_i == LT_LB  ? {{24{b[7]}}, b}
              : loadtype_i == LT_LBU ? {24'd0, b}
              : loadtype_i == LT_LH  ? {{16{h[15]}}, h}
              : loadtype_i == LT_LHU ? {16'd0, h}
              : rdata_i;
    st_be_o = storetype_i == ST_SB ? 4'b0001 << off_i
            : storetype_i == ST_SH ? (off_i[1] ? 4'b1100 : 4'b0011)
            : 4'b1111;
    st_wdata_o = storetype_i == ST_SB ? {4{wdata_i[7:0]}}
               : storetype_i == ST_SH ? {2{wdata_i[15:0]}}
               : wdata_i;
  end
endmodule

// File: rtl/lsu_rv32i.sv
// lsu_rv32i: single-outstanding RV32I load/store unit with a req/gnt/rvalid bus.
// Optional bus watchdog enabled by defining LSU_BUS_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module lsu_rv32i import rv32i_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cu_rdtype,
  input  logic [2:0]  cu_loadtype,
  input  logic        cu_store,
  input  logic [1:0]  cu_storetype,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        lsu_stall,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, ld_data, st_wdata;
  logic [2:0]  lt_q;
  logic [1:0]  st_q;
  logic [3:0]  st_be;
  logic        ld_q, err_q, tmo, is_load, op, bad;
  assign is_load = cu_rdtype == RD_LOAD;
  assign op      = is_load | cu_store;
  assign bad     = lsu_bad(is_load, cu_loadtype, cu_storetype, addr[1:0]);
`ifdef LSU_BUS_TIMEOUT_EN
  logic [7:0] cnt_q;
  // A bus event in the expiry cycle takes precedence over the timeout.
  assign tmo = cnt_q == 8'(TIMEOUT_CYCLES - 1) &&
               ((state_q == S_REQ && !mem_gnt) || (state_q == S_WAIT && !mem_rvalid));
  always_ff @(posedge clk)
    cnt_q <= (rst_n && (state_q == S_REQ || state_q == S_WAIT)) ? cnt_q + 8'd1 : 8'd0;
`else
  logic unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES != 0;
  assign tmo = 1'b0;
`endif
  always_comb
    state_d = state_q == S_IDLE ? (op ? (bad ? S_DONE : S_REQ) : S_IDLE)
            : state_q == S_REQ  ? (mem_gnt ? (ld_q ? S_WAIT : S_DONE) : (tmo ? S_DONE : S_REQ))
            : state_q == S_WAIT ? ((mem_rvalid || tmo) ? S_DONE : S_WAIT)
            : S_IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lt_q    <= '0;
      st_q    <= '0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && op) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        lt_q    <= cu_loadtype;
        st_q    <= cu_storetype;
        ld_q    <= is_load;
        err_q   <= bad;
        rdata_q <= '0;
      end
      if (state_q == S_WAIT && mem_rvalid) rdata_q <= ld_data;
      if (tmo) err_q <= 1'b1;
    end
  end
  lsu_align_rv32i u_align (
    .off_i       (addr_q[1:0]),
    .loadtype_i  (lt_q),
    .storetype_i (st_q),
    .wdata_i     (wdata_q),
    .rdata_i     (mem_rdata),
    .ld_data_o   (ld_data),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata)
  );
  assign mem_req   = state_q == S_REQ;
  assign mem_we    = mem_req & ~ld_q;
  assign mem_be    = mem_req ? (ld_q ? 4'b1111 : st_be) : 4'b0000;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? st_wdata : '0;
  assign lsu_stall = (state_q == S_IDLE && op) || state_q == S_REQ || state_q == S_WAIT;
  assign lsu_err   = state_q == S_DONE && err_q;
  assign lsu_rdata = (state_q == S_DONE && !err_q) ? rdata_q : '0;
endmodule

// File: tb/tb_lsu_rv32i.sv
// tb_lsu_rv32i: directed and randomized checks of lsu_rv32i against a size/offset reference model.
module tb_lsu_rv32i;
`ifdef LSU_BUS_TIMEOUT_EN
  localparam int TMO = 4;
  localparam int MAXD = 1;
`else
  localparam int TMO = 255;
  localparam int MAXD = 3;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] cu_rdtype = '0, cu_storetype = '0;
  logic [2:0] cu_loadtype = '0;
  logic cu_store = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic lsu_stall, lsu_err, mem_req, mem_we;
  logic [31:0] lsu_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int tests = 0, fails = 0;
  logic [31:0] r_rdata, r_wd, r_addr, ra;
  logic r_err, rld;
  logic [3:0] r_be;
  logic [2:0] rlt;
  logic [1:0] rst_t;
  int r_stalls, r_reqs, s;
  bit fin;

  lsu_rv32i #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cu_rdtype(cu_rdtype), .cu_loadtype(cu_loadtype),
    .cu_store(cu_store), .cu_storetype(cu_storetype), .addr(addr), .wdata(wdata),
    .lsu_stall(lsu_stall), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  // Access size in bytes decides legality, lanes and extension.
  function automatic void model(input logic ld, input logic [2:0] lt, input logic [1:0] st,
                                input logic [31:0] a, wd, rd, output logic bad,
                                output logic [3:0] be, output logic [31:0] wde, res);
    int sz, off;
    logic [31:0] mask;
    sz = ld ? ((lt == 3'd0 || lt == 3'd4) ? 1 : (lt == 3'd1 || lt == 3'd5) ? 2 : lt == 3'd2 ? 4 : 0)
            : (st == 2'd0 ? 1 : st == 2'd1 ? 2 : st == 2'd2 ? 4 : 0);
    off = int'(a % 4);
    bad = (sz == 0) || (a % sz != 0);
    be = '0; wde = '0; res = '0;
    if (!bad) begin
      be = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) wde[8*i +: 8] = wd[8*(i % sz) +: 8];
      mask = sz == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
      res = (rd >> (8 * off)) & mask;
      if (!lt[2] && sz < 4 && res[8*sz-1]) res = res | ~mask;
    end
  endfunction

  // Entered and left one time unit after a rising edge with the LSU idle.
  task automatic run_op(input logic ld, input logic [2:0] lt, input logic [1:0] st,
                        input logic [31:0] a, wd, rd, input int gd, rvd,
                        output logic [31:0] o_rdata, output logic o_err, output int o_stalls,
                        output int o_reqs, output logic [3:0] o_be, output logic [31:0] o_wd, o_addr);
    logic bad, granted, hit, done;
    logic [3:0] be;
    logic [31:0] wde, res;
    int gc, wc, cyc, v;
    model(ld, lt, st, a, wd, rd, bad, be, wde, res);
    v = int'($urandom % 3);
    cu_rdtype = ld ? 2'b01 : (v == 0 ? 2'b00 : v == 1 ? 2'b10 : 2'b11);
    cu_store = ld ? 1'($urandom % 2) : 1'b1;
    cu_loadtype = lt; cu_storetype = st; addr = a; wdata = wd; mem_rdata = rd;
    granted = 0; done = 0; gc = 0; wc = 0; cyc = 0;
    o_stalls = 0; o_reqs = 0; o_be = '0; o_wd = '0; o_addr = '0; o_rdata = '0; o_err = 1'b0;
    while (!done && cyc < 64) begin
      mem_gnt = mem_req && gc >= gd;
      mem_rvalid = granted ? (wc >= rvd) : (mem_req ? 1'($urandom % 2) : 1'b0);
      if (mem_req) gc++;
      if (granted) wc++;
      @(negedge clk);
      if (lsu_stall) o_stalls++;
      if (mem_req) begin
        o_reqs++;
        o_be = mem_be; o_wd = mem_wdata; o_addr = mem_addr;
        chk("req_addr", mem_addr, {a[31:2], 2'b00});
        chk("req_we", 32'(mem_we), 32'(!ld));
        if (!ld) begin
          chk("req_be", 32'(mem_be), 32'(be));
          chk("req_wdata", mem_wdata, wde);
        end
      end else begin
        chk("idle_we", 32'(mem_we), 0);
        chk("idle_be", 32'(mem_be), 0);
      end
      if (!lsu_stall) begin
        done = 1; o_rdata = lsu_rdata; o_err = lsu_err;
      end
      hit = mem_req && mem_gnt;
      @(posedge clk); #1;
      cyc++;
      if (hit) granted = 1;
    end
    cu_rdtype = 2'b00; cu_store = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("op_done", 32'(done), 1);
    chk("op_err", 32'(o_err), 32'(bad));
    if (ld || bad) chk("op_rdata", o_rdata, bad ? 32'd0 : res);
    chk("op_stalls", 32'(o_stalls), 32'(bad ? 1 : ld ? gd + rvd + 3 : gd + 2));
    chk("op_reqs", 32'(o_reqs), 32'(bad ? 0 : gd + 1));
    @(negedge clk);
    chk("post_rdata", lsu_rdata, 0);
    chk("post_err", 32'(lsu_err), 0);
    chk("post_stall", 32'(lsu_stall), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", lsu_rdata, 0);
    chk("rst_err", 32'(lsu_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(1, 3'b000, 2'b00, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0,
           r_rdata, r_err, r_stalls, r_reqs, r_be, r_wd, r_addr);
    chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
    chk("lb_stalls", 32'(r_stalls), 3);

    run_op(0, 3'b000, 2'b01, 32'h2002, 32'h0000_ABCD, 32'h0, 0, 0,
           r_rdata, r_err, r_stalls, r_reqs, r_be, r_wd, r_addr);
    chk("sh_be", 32'(r_be), 32'b1100);
    chk("sh_wdata", r_wd, 32'hABCD_ABCD);
    chk("sh_addr", r_addr, 32'h2000);
    chk("sh_stalls", 32'(r_stalls), 2);

    run_op(1, 3'b010, 2'b00, 32'h3001, 32'h0, 32'h1234_5678, 0, 0,
           r_rdata, r_err, r_stalls, r_reqs, r_be, r_wd, r_addr);
    chk("lw_mis_err", 32'(r_err), 1);
    chk("lw_mis_rdata", r_rdata, 0);
    chk("lw_mis_stalls", 32'(r_stalls), 1);
    chk("lw_mis_reqs", 32'(r_reqs), 0);

`ifndef LSU_BUS_TIMEOUT_EN
    run_op(0, 3'b000, 2'b10, 32'h6004, 32'hCAFE_F00D, 32'h0, 5, 0,
           r_rdata, r_err, r_stalls, r_reqs, r_be, r_wd, r_addr);
    chk("gnt_wait_stalls", 32'(r_stalls), 7);
    chk("gnt_wait_reqs", 32'(r_reqs), 6);
    chk("gnt_wait_wdata", r_wd, 32'hCAFE_F00D);
`endif

    cu_rdtype = 2'b01; cu_loadtype = 3'b010; addr = 32'h4000; cu_store = 1'b0;
    @(posedge clk); #1;
    chk("abort_req", 32'(mem_req), 1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; cu_rdtype = 2'b00;
    chk("abort_wait_stall", 32'(lsu_stall), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("abort_stall", 32'(lsu_stall), 0);
    chk("abort_mreq", 32'(mem_req), 0);
    chk("abort_be", 32'(mem_be), 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_rdata", lsu_rdata, 0);
    chk("abort_err", 32'(lsu_err), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stray_rdata", lsu_rdata, 0);
    chk("stray_stall", 32'(lsu_stall), 0);
    chk("stray_req", 32'(mem_req), 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_gnt = 1'b0;

`ifdef LSU_BUS_TIMEOUT_EN
    cu_rdtype = 2'b01; cu_loadtype = 3'b010; addr = 32'h5000;
    s = 0; fin = 0;
    for (int c = 0; c < 20 && !fin; c++) begin
      mem_gnt = mem_req;
      @(negedge clk);
      if (lsu_stall) s++;
      else begin
        fin = 1;
        chk("tmo_err", 32'(lsu_err), 1);
        chk("tmo_rdata", lsu_rdata, 0);
        chk("tmo_req", 32'(mem_req), 0);
      end
      @(posedge clk); #1;
    end
    cu_rdtype = 2'b00; mem_gnt = 1'b0;
    chk("tmo_done", 32'(fin), 1);
    chk("tmo_stalls", 32'(s), 5);
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 40; i++) begin
      rld = 1'($urandom % 2);
      rlt = 3'($urandom % 8);
      rst_t = 2'($urandom % 4);
      ra = $urandom;
      if ($urandom % 2 == 0) ra[1:0] = 2'b00;
      run_op(rld, rlt, rst_t, ra, $urandom, $urandom,
             int'($urandom_range(0, MAXD)), int'($urandom_range(0, MAXD)),
             r_rdata, r_err, r_stalls, r_reqs, r_be, r_wd, r_addr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
